ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter ISA_WIDTH, default 32, giving the instruction and address width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  ISA_WIDTH  read address, equal to pc.
REQ-007 mem_ack  input  1  read data valid this cycle.
REQ-008 mem_rdata  input  ISA_WIDTH  instruction word, valid when mem_ack is high.
REQ-009 mem_err  input  1  bus error, qualified by mem_ack.
REQ-010 inst  output  ISA_WIDTH  instruction to the decode stage (funct3/opcode decoders).
REQ-011 pc  output  ISA_WIDTH  address of inst.
REQ-012 inst_valid  output  1  inst/pc valid for decode.
REQ-013 inst_ready  input  1  decode accepts inst this cycle.
REQ-014 next_pc  input  ISA_WIDTH  PC of the following instruction, from execute/writeback.
REQ-015 next_pc_valid  input  1  next_pc valid; marks retirement of the current instruction.
REQ-016 fault  output  1  sticky fetch fault flag.
REQ-017 retire_cnt  output  32  count of accepted next_pc updates.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, FETCH, ISSUE, WAIT_PC and FAULT, all registered.
REQ-019 IDLE SHALL go to FETCH on the first cycle rst is low.
REQ-020 FETCH SHALL drive mem_req=1 and mem_addr=pc, and SHALL hold both stable until mem_ack.
REQ-021 mem_ack in FETCH with mem_err=0 SHALL latch mem_rdata into the instruction register and go to ISSUE.
REQ-022 mem_ack in FETCH with mem_err=1 SHALL go to FAULT and leave the instruction register unchanged.
REQ-023 mem_ack in the same cycle as the first mem_req cycle SHALL be accepted, because zero-wait memory is legal.
REQ-024 mem_ack outside FETCH SHALL be ignored.
REQ-025 ISSUE SHALL drive inst_valid=1, and SHALL hold inst and pc stable until inst_ready.
REQ-026 ISSUE with inst_ready=1 and next_pc_valid=0 SHALL go to WAIT_PC.
REQ-027 ISSUE with inst_ready=1 and next_pc_valid=1 in the same cycle SHALL load pc from next_pc and go directly to FETCH (single-cycle execute path).
REQ-028 WAIT_PC with next_pc_valid=1 SHALL load pc from next_pc and go to FETCH.
REQ-029 next_pc_valid SHALL be ignored in IDLE, in FETCH, in FAULT, and in ISSUE without inst_ready.
REQ-030 An accepted next_pc with next_pc[1:0] not equal to 0 SHALL go to FAULT, with pc still loaded from next_pc.
REQ-031 Every accepted next_pc, including a misaligned one, SHALL increment retire_cnt by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-032 FAULT SHALL drive fault=1, mem_req=0 and inst_valid=0, and SHALL be left only by rst.
REQ-033 mem_req SHALL be 0 and inst_valid SHALL be 0 in every state not listed for them above.
REQ-034 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with ack, then ISSUE with ready and next_pc_valid).

Reset
REQ-035 rst=1 SHALL set, on the next edge: state=IDLE, pc=RESET_PC, the instruction register=0, retire_cnt=0 and fault=0.
REQ-036 As a result of REQ-035, mem_req=0 and inst_valid=0 from that edge.
REQ-037 rst asserted mid-transaction (FETCH awaiting ack, or ISSUE awaiting ready) SHALL abandon the transaction.
REQ-038 A mem_ack arriving in the reset cycle, or in IDLE, SHALL be dropped.
REQ-039 rst SHALL take priority over every other input.

Verification
REQ-040 Zero-wait path: release rst; ack with rdata=32'h0010_0093 in the first FETCH cycle; hold inst_ready=1 and next_pc_valid=1 with next_pc=32'h8000_0004 -> inst=32'h0010_0093 with pc=32'h8000_0000 for 1 cycle; next mem_addr=32'h8000_0004; retire_cnt=1.
REQ-041 Wait states: delay mem_ack by 3 cycles -> mem_req and mem_addr are stable for all 4 cycles; inst_valid rises the cycle after ack.
REQ-042 Decode backpressure: hold inst_ready=0 for 5 cycles in ISSUE -> inst, pc and inst_valid are unchanged throughout; next_pc_valid pulses in that window are ignored and retire_cnt is unchanged.
REQ-043 Bus error: mem_ack=1 with mem_err=1 -> fault=1 the next cycle; mem_req stays 0 and inst_valid stays 0 until rst.
REQ-044 Misaligned redirect: next_pc=32'h8000_0006 accepted in WAIT_PC -> fault=1, pc=32'h8000_0006, retire_cnt increments, no further mem_req.
REQ-045 Reset mid-fetch: rst asserted while in FETCH, then mem_ack in the reset cycle -> no inst_valid; after release the first mem_addr is 32'h8000_0000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit signal bundle: instruction memory read port, decode handoff and retire/redirect feedback.
// master = the fetch unit, slave = the memory/decode/execute side that surrounds it.
interface ifu_fetch_if #(
  parameter int ISA_WIDTH = 32
);
  logic                 mem_req;
  logic [ISA_WIDTH-1:0] mem_addr;
  logic                 mem_ack;
  logic [ISA_WIDTH-1:0] mem_rdata;
  logic                 mem_err;
  logic [ISA_WIDTH-1:0] inst;
  logic [ISA_WIDTH-1:0] pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [ISA_WIDTH-1:0] next_pc;
  logic                 next_pc_valid;
  logic                 fault;
  logic [31:0]          retire_cnt;

  modport master (
    output mem_req, mem_addr, inst, pc, inst_valid, fault, retire_cnt,
    input  mem_ack, mem_rdata, mem_err, inst_ready, next_pc, next_pc_valid
  );

  modport slave (
    input  mem_req, mem_addr, inst, pc, inst_valid, fault, retire_cnt,
    output mem_ack, mem_rdata, mem_err, inst_ready, next_pc, next_pc_valid
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: fetches at pc, hands the word to decode,
// then waits for the retiring instruction to supply the next pc.
//
// state   | meaning
// IDLE    | out of reset, fetch starts next cycle
// FETCH   | mem_req high at pc, waiting for mem_ack
// ISSUE   | inst/pc offered to decode, waiting for inst_ready
// WAIT_PC | decode took inst, waiting for next_pc_valid
// FAULT   | bus error or misaligned redirect; only rst leaves
module ifu_fetch #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_PC = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ISA_WIDTH-1:0] r_pc;
  logic [ISA_WIDTH-1:0] r_inst;
  logic [31:0]          r_retire_cnt;

  logic w_ack_ok;
  logic w_ack_err;
  logic w_pc_take;
  logic w_misaligned;
  logic w_mem_req;
  logic w_inst_valid;
  logic w_fault;

  assign w_ack_ok     = (r_state == S_FETCH) && bus.mem_ack && !bus.mem_err;
  assign w_ack_err    = (r_state == S_FETCH) && bus.mem_ack &&  bus.mem_err;
  // A redirect counts only when the current instruction has been (or is being) accepted.
  assign w_pc_take    = bus.next_pc_valid &&
                        (((r_state == S_ISSUE) && bus.inst_ready) || (r_state == S_WAIT_PC));
  assign w_misaligned = |bus.next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_ack_err) begin
          w_state_nxt = S_FAULT;
        end else if (w_ack_ok) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.inst_ready) begin
          if (w_pc_take) begin
            w_state_nxt = w_misaligned ? S_FAULT : S_FETCH;
          end else begin
            w_state_nxt = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (w_pc_take) begin
          w_state_nxt = w_misaligned ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_mem_req    = 1'b0;
    w_inst_valid = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      S_FETCH: w_mem_req    = 1'b1;
      S_ISSUE: w_inst_valid = 1'b1;
      S_FAULT: w_fault      = 1'b1;
      default: ;
    endcase
  end

  // pc is loaded even for a misaligned target so the faulting address stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_ack_ok) begin
        r_inst <= bus.mem_rdata;
      end
      if (w_pc_take) begin
        r_pc         <= bus.next_pc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_addr   = r_pc;
  assign bus.inst       = r_inst;
  assign bus.pc         = r_pc;
  assign bus.inst_valid = w_inst_valid;
  assign bus.fault      = w_fault;
  assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios then randomized memory/decode traffic,
// checked against a transaction-level model of fetch, handoff and retirement.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if #(.ISA_WIDTH(32)) bus ();

  ifu_fetch #(.ISA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;

  // Reference model: what the fetch unit is doing, in transaction terms.
  bit          m_boot   = 1'b1;   // first cycle after reset, no request yet
  bit          m_have   = 1'b0;   // a fetched word is waiting for decode
  bit          m_flight = 1'b0;   // decode holds the word, retirement pending
  bit          m_dead   = 1'b0;   // faulted until reset
  logic [31:0] m_pc     = RST_PC;
  logic [31:0] m_inst   = '0;
  logic [31:0] m_cnt    = '0;

  function automatic bit m_fetching();
    return !m_boot && !m_have && !m_flight && !m_dead;
  endfunction

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic void retire(logic [31:0] npc);
    m_pc  = npc;
    m_cnt = m_cnt + 32'd1;
    if (npc[1:0] != 2'b00) m_dead = 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs that were applied for it.
  function automatic void model_step();
    if (rst) begin
      m_boot = 1'b1; m_have = 1'b0; m_flight = 1'b0; m_dead = 1'b0;
      m_pc = RST_PC; m_inst = '0; m_cnt = '0;
      sb_q.delete();
    end else if (m_dead) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fetching()) begin
      if (bus.mem_ack) begin
        if (bus.mem_err) begin
          m_dead = 1'b1;
        end else begin
          m_have = 1'b1;
          m_inst = bus.mem_rdata;
          sb_q.push_back('{pc: m_pc, inst: bus.mem_rdata});
        end
      end
    end else if (m_have) begin
      if (bus.inst_ready) begin
        m_have = 1'b0;
        if (bus.next_pc_valid) retire(bus.next_pc);
        else m_flight = 1'b1;
      end
    end else if (m_flight) begin
      if (bus.next_pc_valid) begin
        m_flight = 1'b0;
        retire(bus.next_pc);
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit a, input bit e, input logic [31:0] rd,
                     input bit rdy, input bit nv, input logic [31:0] np);
    rst               = r;
    bus.mem_ack       = a;
    bus.mem_err       = e;
    bus.mem_rdata     = rd;
    bus.inst_ready    = rdy;
    bus.next_pc_valid = nv;
    bus.next_pc       = np;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_req", 32'(bus.mem_req), 32'(m_fetching()));
      if (m_fetching()) chk("mem_addr", bus.mem_addr, m_pc);
      chk("inst_valid", 32'(bus.inst_valid), 32'(m_have));
      chk("fault", 32'(bus.fault), 32'(m_dead));
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      chk("pc", bus.pc, m_pc);
      chk("inst", bus.inst, m_inst);
      if (bus.inst_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got inst_valid=1 expected no pending fetch at %0t", $time);
        end else begin
          chk("sb_inst", bus.inst, sb_q[0].inst);
          chk("sb_pc", bus.pc, sb_q[0].pc);
          if (bus.inst_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit          fetching;
    bit          r, a, e, rdy, nv;
    logic [31:0] np;

    cyc(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    cyc(1, 1, 0, 32'hFFFF_FFFF, 1, 1, 32'h1234_5678);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_req", 32'(bus.mem_req), 32'h0);

    // Zero-wait path with single-cycle execute.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h0010_0093, 1, 1, 32'h8000_0004);
    chk("zw_valid", 32'(bus.inst_valid), 32'h1);
    chk("zw_inst", bus.inst, 32'h0010_0093);
    chk("zw_pc", bus.pc, 32'h8000_0000);
    cyc(0, 1, 0, 32'h0010_0093, 1, 1, 32'h8000_0004);
    chk("zw_valid_drop", 32'(bus.inst_valid), 32'h0);
    chk("zw_next_addr", bus.mem_addr, 32'h8000_0004);
    chk("zw_next_req", 32'(bus.mem_req), 32'h1);
    chk("zw_retire", bus.retire_cnt, 32'd1);

    // Three wait states before the ack.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'hBAD0_0000, 0, 0, 0);
    chk("ws_addr", bus.mem_addr, 32'h8000_0004);
    cyc(0, 1, 0, 32'h0020_0113, 0, 0, 0);
    chk("ws_valid", 32'(bus.inst_valid), 32'h1);

    // Decode backpressure; redirect pulses must be ignored.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'hDEAD_0000, 0, (i % 2) == 1, 32'h9000_0000);
    chk("bp_inst", bus.inst, 32'h0020_0113);
    chk("bp_retire", bus.retire_cnt, 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0008);
    chk("wp_addr", bus.mem_addr, 32'h8000_0008);

    // Misaligned redirect from the wait-for-pc point.
    cyc(0, 1, 0, 32'h0030_0193, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0006);
    chk("mis_fault", 32'(bus.fault), 32'h1);
    chk("mis_pc", bus.pc, 32'h8000_0006);
    chk("mis_retire", bus.retire_cnt, 32'd3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h1111_1111, 1, 1, 32'h8000_0010);

    // Bus error.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'hDEAD_BEEF, 1, 1, 32'h8000_0004);
    chk("err_fault", 32'(bus.fault), 32'h1);
    chk("err_inst", bus.inst, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h2222_2222, 1, 1, 32'h8000_0004);

    // Reset while a fetch is outstanding, with an ack in the reset cycle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'h1234_5678, 1, 0, 0);
    chk("rf_valid", 32'(bus.inst_valid), 32'h0);
    chk("rf_inst", bus.inst, 32'h0);
    cyc(0, 1, 0, 32'h1234_5678, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rf_addr", bus.mem_addr, RST_PC);
    chk("rf_req", 32'(bus.mem_req), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      fetching = m_fetching();
      r = ($urandom_range(0, 299) == 0) || (m_dead && ($urandom_range(0, 7) == 0));
      if (fetching) begin
        a = ($urandom_range(0, 9) < 4);
        e = a && ($urandom_range(0, 49) == 0);
      end else begin
        a = ($urandom_range(0, 4) == 0);
        e = $urandom_range(0, 1) == 1;
      end
      rdy = ($urandom_range(0, 9) < 6);
      nv  = ($urandom_range(0, 9) < 4);
      np  = {16'h8000, 14'($urandom), 2'b00};
      if ($urandom_range(0, 39) == 0) np[1:0] = 2'($urandom_range(1, 3));
      cyc(r, a, e, $urandom, rdy, nv, np);
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
